// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the NREQ requesters / decode stage and the register-file write arbiter.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_rd;
    logic [NREQ*DW-1:0] req_data;
    logic [AW-1:0]      Ra;
    logic [AW-1:0]      Rb;
    logic               hazA;
    logic               hazB;
    logic               WE;
    logic [AW-1:0]      Rw;
    logic [DW-1:0]      busW;
    logic [IDW-1:0]     grant_id;
    logic [31:0]        wr_count;

    modport master (
        output req_valid, req_rd, req_data, Ra, Rb,
        input  req_ready, hazA, hazB, WE, Rw, busW, grant_id, wr_count
    );

    modport slave (
        input  req_valid, req_rd, req_data, Ra, Rb,
        output req_ready, hazA, hazB, WE, Rw, busW, grant_id, wr_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port, with RAW hazard flags for Ra/Rb.
// Optional WB_ZERO_FILTER_EN: rd==0 requests are accepted at once and never reach the write port.
module regfile_wb_lane #(
    parameter int AW = 5
) (
    input  logic          valid,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] Ra,
    input  logic [AW-1:0] Rb,
    output logic          isZero,
    output logic          matchA,
    output logic          matchB
);
    assign isZero = (rd == '0);
    assign matchA = valid && (Ra != '0) && (rd == Ra);
    assign matchB = valid && (Rb != '0) && (rd == Rb);
endmodule

module regfile_wb_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int IDW  = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    regfile_wb_arbiter_if.slave  bus
);
    logic [NREQ-1:0][AW-1:0] rdLane;
    logic [NREQ-1:0][DW-1:0] dataLane;
    logic [NREQ-1:0]         zeroMask, hitA, hitB, eligible, readyV;
    logic [IDW-1:0]          ptr, winIdx;
    logic                    winFound;

    for (genvar g = 0; g < NREQ; g++) begin : gLane
        assign rdLane[g]   = bus.req_rd[g*AW +: AW];
        assign dataLane[g] = bus.req_data[g*DW +: DW];
        regfile_wb_lane #(.AW(AW)) uLane (
            .valid  (bus.req_valid[g]),
            .rd     (rdLane[g]),
            .Ra     (bus.Ra),
            .Rb     (bus.Rb),
            .isZero (zeroMask[g]),
            .matchA (hitA[g]),
            .matchB (hitB[g])
        );
    end

`ifdef WB_ZERO_FILTER_EN
    assign eligible = bus.req_valid & ~zeroMask;
`else
    assign eligible = bus.req_valid;
`endif

    // Scan starts at ptr and wraps, so the last winner becomes lowest priority.
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!winFound && eligible[(int'(ptr) + k) % NREQ]) begin
                winFound = 1'b1;
                winIdx   = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        readyV = '0;
        if (!RST) begin
            if (winFound) readyV[winIdx] = 1'b1;
`ifdef WB_ZERO_FILTER_EN
            readyV = readyV | (bus.req_valid & zeroMask);
`endif
        end
    end

    assign bus.req_ready = readyV;
    assign bus.hazA      = |hitA;
    assign bus.hazB      = |hitB;

    // Write is registered so it is stable across the register file's negedge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.WE       <= 1'b0;
            bus.Rw       <= '0;
            bus.busW     <= '0;
            bus.grant_id <= '0;
            bus.wr_count <= '0;
            ptr          <= '0;
        end else if (winFound) begin
            bus.WE       <= 1'b1;
            bus.Rw       <= rdLane[winIdx];
            bus.busW     <= dataLane[winIdx];
            bus.grant_id <= winIdx;
            bus.wr_count <= bus.wr_count + 32'd1;
            ptr          <= (winIdx == IDW'(NREQ - 1)) ? '0 : winIdx + 1'b1;
        end else begin
            bus.WE       <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-level behavioural model.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 4, DW = 32, AW = 5, IDW = 2;
`ifdef WB_ZERO_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    regfile_wb_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW), .IDW(IDW)) bus ();
    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .IDW(IDW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int tests = 0, fails = 0;

    // Model: pending request per requester, expected registered write, pointer, count.
    logic          pv[NREQ];
    logic [AW-1:0] prd[NREQ];
    logic [DW-1:0] pdat[NREQ];
    int            mPtr = 0;
    int unsigned   mCount = 0;
    logic          expWE = 1'b0;
    logic [AW-1:0] expRw = '0;
    logic [DW-1:0] expBusW = '0;
    int            expGid = 0;
    logic [DW-1:0] regs[32];

    always @(negedge CLK) if (bus.WE === 1'b1 && bus.Rw != 0) regs[bus.Rw] <= bus.busW;

    function automatic int mWin();
        for (int k = 0; k < NREQ; k++) begin
            int i = (mPtr + k) % NREQ;
            if (pv[i] && !(FILTER && prd[i] == 0)) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] mReady();
        logic [NREQ-1:0] r = '0;
        int w = mWin();
        if (RST) return '0;
        if (w >= 0) r[w] = 1'b1;
        for (int i = 0; i < NREQ; i++) if (FILTER && pv[i] && prd[i] == 0) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic mHaz(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        for (int i = 0; i < NREQ; i++) if (pv[i] && prd[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic setReq(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        pv[i] = 1'b1; prd[i] = rd; pdat[i] = d;
    endtask

    task automatic applyReqs();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]         = pv[i];
            bus.req_rd[i*AW +: AW]   = prd[i];
            bus.req_data[i*DW +: DW] = pdat[i];
        end
        #1;
    endtask

    // Advance one clock, updating the model with what the spec says the edge does.
    task automatic tick();
        int w;
        w = RST ? -1 : mWin();
        if (RST) begin
            expWE = 0; expRw = 0; expBusW = 0; expGid = 0; mCount = 0; mPtr = 0;
        end else begin
            if (w >= 0) begin
                expWE = 1; expRw = prd[w]; expBusW = pdat[w]; expGid = w;
                mCount++; mPtr = (w + 1) % NREQ; pv[w] = 0;
            end else expWE = 0;
            for (int i = 0; i < NREQ; i++) if (FILTER && pv[i] && prd[i] == 0) pv[i] = 0;
        end
        @(posedge CLK); #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 2*NREQ; n++) begin
            tick(); applyReqs();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) setReq(i, AW'(i + 1), 32'h1000_0000 + i);
        RST = 1'b1;
        applyReqs();
        tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
        tick(); tick();
        tests++;
        if (bus.WE !== 1'b0 || bus.Rw !== '0 || bus.busW !== '0 || bus.grant_id !== '0 || bus.wr_count !== 32'd0) begin
            fails++; $display("FAIL reset_regs WE=%b Rw=%0d busW=%h gid=%0d cnt=%0d exp all 0",
                              bus.WE, bus.Rw, bus.busW, bus.grant_id, bus.wr_count);
        end
        RST = 1'b0; #1;
        tests++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL reset_first_grant got=%b exp=0001", bus.req_ready); end
        for (int k = 0; k < NREQ; k++) begin
            tick(); applyReqs();
            tests++;
            if (bus.WE !== 1'b1 || bus.grant_id !== IDW'(k) || bus.busW !== 32'h1000_0000 + k) begin
                fails++; $display("FAIL reset_drain k=%0d WE=%b gid=%0d busW=%h", k, bus.WE, bus.grant_id, bus.busW);
            end
        end
        tests++; if (bus.wr_count !== 32'd4) begin fails++; $display("FAIL reset_count got=%0d exp=4", bus.wr_count); end
    endtask

    task automatic test_single();
        setReq(2, 5'd5, 32'hDEADBEEF);
        applyReqs();
        tests++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready got=%b exp=0100", bus.req_ready); end
        tick(); applyReqs();
        tests++;
        if (bus.WE !== 1'b1 || bus.Rw !== 5'd5 || bus.busW !== 32'hDEADBEEF || bus.grant_id !== 2'd2 || bus.wr_count !== mCount) begin
            fails++; $display("FAIL single_commit WE=%b Rw=%0d busW=%h gid=%0d cnt=%0d exp 1/5/deadbeef/2/%0d",
                              bus.WE, bus.Rw, bus.busW, bus.grant_id, bus.wr_count, mCount);
        end
        @(negedge CLK); #1;
        tests++; if (regs[5] !== 32'hDEADBEEF) begin fails++; $display("FAIL single_regfile got=%h exp=deadbeef", regs[5]); end
        tick();
        tests++; if (bus.WE !== 1'b0 || bus.Rw !== 5'd5 || bus.busW !== 32'hDEADBEEF) begin
            fails++; $display("FAIL single_idle_hold WE=%b Rw=%0d busW=%h", bus.WE, bus.Rw, bus.busW);
        end
    endtask

    task automatic test_round_robin();
        int start = mPtr;
        int unsigned cnt0 = mCount;
        for (int k = 0; k < 2*NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) if (!pv[i]) setReq(i, AW'($urandom_range(1, 31)), $urandom);
            applyReqs();
            tests++; if (bus.req_ready !== 4'(1 << ((start + k) % NREQ))) begin
                fails++; $display("FAIL rr_ready k=%0d got=%b", k, bus.req_ready);
            end
            tick();
            tests++; if (bus.WE !== 1'b1 || bus.grant_id !== IDW'((start + k) % NREQ) || bus.busW !== expBusW) begin
                fails++; $display("FAIL rr_grant k=%0d WE=%b gid=%0d exp=%0d", k, bus.WE, bus.grant_id, (start + k) % NREQ);
            end
        end
        tests++; if (bus.wr_count !== cnt0 + 8) begin fails++; $display("FAIL rr_count got=%0d exp=%0d", bus.wr_count, cnt0 + 8); end
        applyReqs(); drain();
    endtask

    task automatic test_wrap();
        setReq(2, 5'd3, 32'h2222); applyReqs(); tick(); applyReqs();
        setReq(1, 5'd4, 32'h1111); applyReqs();
        tests++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL wrap_ready1 got=%b exp=0010", bus.req_ready); end
        tick(); applyReqs();
        tests++; if (bus.grant_id !== 2'd1 || bus.Rw !== 5'd4) begin fails++; $display("FAIL wrap_grant1 gid=%0d Rw=%0d", bus.grant_id, bus.Rw); end
        setReq(0, 5'd6, 32'h0); setReq(2, 5'd8, 32'h2); applyReqs();
        tests++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL wrap_skip got=%b exp=0100", bus.req_ready); end
        tick(); applyReqs();
        tests++; if (bus.grant_id !== 2'd2 || bus.Rw !== 5'd8) begin fails++; $display("FAIL wrap_grant2 gid=%0d Rw=%0d", bus.grant_id, bus.Rw); end
        drain();
    endtask

    task automatic test_hazard();
        setReq(3, 5'd1, 32'h3); applyReqs(); tick(); applyReqs();
        setReq(0, 5'd4, 32'hA0); setReq(3, 5'd7, 32'hA3);
        bus.Ra = 5'd7; bus.Rb = 5'd0; applyReqs();
        tests++; if (bus.req_ready !== 4'b0001 || bus.hazA !== 1'b1 || bus.hazB !== 1'b0) begin
            fails++; $display("FAIL haz_wait ready=%b hazA=%b hazB=%b exp 0001/1/0", bus.req_ready, bus.hazA, bus.hazB);
        end
        bus.Rb = 5'd4; #1;
        tests++; if (bus.hazB !== 1'b1) begin fails++; $display("FAIL haz_granted_b got=%b exp=1", bus.hazB); end
        tick(); applyReqs();
        tests++; if (bus.req_ready !== 4'b1000 || bus.hazA !== 1'b1 || bus.hazB !== 1'b0) begin
            fails++; $display("FAIL haz_second ready=%b hazA=%b hazB=%b exp 1000/1/0", bus.req_ready, bus.hazA, bus.hazB);
        end
        tick(); applyReqs();
        tests++; if (bus.WE !== 1'b1 || bus.Rw !== 5'd7 || bus.hazA !== 1'b0) begin
            fails++; $display("FAIL haz_drop WE=%b Rw=%0d hazA=%b exp 1/7/0", bus.WE, bus.Rw, bus.hazA);
        end
        setReq(1, 5'd0, 32'hFF); bus.Ra = 5'd0; applyReqs();
        tests++; if (bus.hazA !== 1'b0) begin fails++; $display("FAIL haz_r0 got=%b exp=0", bus.hazA); end
        drain();
    endtask

    task automatic test_zero_reg();
        int unsigned cnt0 = mCount;
        logic sawZero = 1'b0, sawNine = 1'b0;
        setReq(1, 5'd0, 32'h0BAD); setReq(2, 5'd9, 32'h0099); applyReqs();
        tests++; if (bus.req_ready !== mReady()) begin fails++; $display("FAIL zero_ready got=%b exp=%b", bus.req_ready, mReady()); end
        for (int n = 0; n < 2; n++) begin
            tick(); applyReqs();
            if (bus.WE === 1'b1 && bus.Rw == 0) sawZero = 1'b1;
            if (bus.WE === 1'b1 && bus.Rw == 9) sawNine = 1'b1;
        end
        tests++;
        if (sawNine !== 1'b1 || sawZero !== !FILTER || bus.wr_count !== cnt0 + (FILTER ? 1 : 2)) begin
            fails++; $display("FAIL zero_commit nine=%b zero=%b cnt=%0d exp nine=1 zero=%b cnt=%0d",
                              sawNine, sawZero, bus.wr_count, !FILTER, cnt0 + (FILTER ? 1 : 2));
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            RST = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < NREQ; i++)
                if (!pv[i] && $urandom_range(0, 1) == 1) setReq(i, AW'($urandom_range(0, 7)), $urandom);
            bus.Ra = AW'($urandom_range(0, 7));
            bus.Rb = AW'($urandom_range(0, 7));
            applyReqs();
            tests++;
            if (bus.req_ready !== mReady() || bus.hazA !== mHaz(bus.Ra) || bus.hazB !== mHaz(bus.Rb)) begin
                fails++; $display("FAIL rand_comb c=%0d ready=%b/%b hazA=%b/%b hazB=%b/%b", c,
                                  bus.req_ready, mReady(), bus.hazA, mHaz(bus.Ra), bus.hazB, mHaz(bus.Rb));
            end
            tick();
            tests++;
            if (bus.WE !== expWE || bus.Rw !== expRw || bus.busW !== expBusW ||
                bus.grant_id !== IDW'(expGid) || bus.wr_count !== mCount) begin
                fails++; $display("FAIL rand_commit c=%0d WE=%b/%b Rw=%0d/%0d busW=%h/%h gid=%0d/%0d cnt=%0d/%0d", c,
                                  bus.WE, expWE, bus.Rw, expRw, bus.busW, expBusW, bus.grant_id, expGid, bus.wr_count, mCount);
            end
        end
        RST = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin pv[i] = 0; prd[i] = '0; pdat[i] = '0; end
        bus.Ra = '0; bus.Rb = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_hazard();
        test_zero_reg();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
